// File: rtl/alu_rs.sv
// Reservation station in front of the single-cycle ALU: buffers renamed ops, snoops the CDB, dispatches one ready op per cycle.
// Optional oldest-first selection is compiled in with `define ALU_RS_AGE_ORDER_EN (default: lowest ready index wins).
module alu_rs #(
    parameter int ROB_IX      = 2,
    parameter int NUM_ENTRIES = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             flush_in,
    input  logic                             issue_valid_in,
    output logic                             issue_ready_out,
    input  logic [3:0]                       issue_aluFunc_in,
    input  logic [ROB_IX:0]                  issue_rob_ix_in,
    input  logic [31:0]                      issue_v1_in,
    input  logic [31:0]                      issue_v2_in,
    input  logic                             issue_rdy1_in,
    input  logic                             issue_rdy2_in,
    input  logic [ROB_IX:0]                  issue_q1_in,
    input  logic [ROB_IX:0]                  issue_q2_in,
    input  logic                             cdb_valid_in,
    input  logic [ROB_IX:0]                  cdb_rob_ix_in,
    input  logic [31:0]                      cdb_data_in,
    input  logic                             alu_ready_in,
    output logic                             alu_valid_out,
    output logic [31:0]                      alu_rval1_out,
    output logic [31:0]                      alu_rval2_out,
    output logic [3:0]                       alu_aluFunc_out,
    output logic [ROB_IX:0]                  alu_rob_ix_out,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] count_out
);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CW = $clog2(NUM_ENTRIES + 1);

    logic              busy_reg [NUM_ENTRIES];
    logic [3:0]        func_reg [NUM_ENTRIES];
    logic [ROB_IX:0]   rob_reg  [NUM_ENTRIES];
    logic [31:0]       v1_reg   [NUM_ENTRIES];
    logic [31:0]       v2_reg   [NUM_ENTRIES];
    logic              rdy1_reg [NUM_ENTRIES];
    logic              rdy2_reg [NUM_ENTRIES];
    logic [ROB_IX:0]   q1_reg   [NUM_ENTRIES];
    logic [ROB_IX:0]   q2_reg   [NUM_ENTRIES];
`ifdef ALU_RS_AGE_ORDER_EN
    logic [IW-1:0]     age_reg  [NUM_ENTRIES];
`endif

    logic [CW-1:0]     count_reg;
    logic              alu_valid_reg;
    logic [31:0]       alu_rval1_reg;
    logic [31:0]       alu_rval2_reg;
    logic [3:0]        alu_func_reg;
    logic [ROB_IX:0]   alu_rob_reg;

    logic [NUM_ENTRIES-1:0] cand;
    logic [NUM_ENTRIES-1:0] hit1;
    logic [NUM_ENTRIES-1:0] hit2;
    logic [IW-1:0]          free_ix;
    logic [IW-1:0]          sel_ix;
    logic                   sel_found;
    logic                   issue_fire;
    logic                   dispatch;
    logic                   new_rdy1;
    logic                   new_rdy2;
    logic [31:0]            new_v1;
    logic [31:0]            new_v2;

    // Readiness and CDB tag matches are evaluated on registered state only.
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        assign cand[gi] = busy_reg[gi] && rdy1_reg[gi] && rdy2_reg[gi];
        assign hit1[gi] = busy_reg[gi] && !rdy1_reg[gi] && cdb_valid_in && (q1_reg[gi] == cdb_rob_ix_in);
        assign hit2[gi] = busy_reg[gi] && !rdy2_reg[gi] && cdb_valid_in && (q2_reg[gi] == cdb_rob_ix_in);
    end

    assign issue_ready_out = (count_reg < CW'(NUM_ENTRIES));
    assign issue_fire      = issue_valid_in && issue_ready_out;
    assign dispatch        = sel_found && alu_ready_in;

    // An operand broadcast in the same cycle as issue is captured on the way in.
    assign new_rdy1 = issue_rdy1_in || (cdb_valid_in && (issue_q1_in == cdb_rob_ix_in));
    assign new_rdy2 = issue_rdy2_in || (cdb_valid_in && (issue_q2_in == cdb_rob_ix_in));
    assign new_v1   = issue_rdy1_in ? issue_v1_in : cdb_data_in;
    assign new_v2   = issue_rdy2_in ? issue_v2_in : cdb_data_in;

    always_comb begin
        free_ix = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy_reg[i]) free_ix = IW'(i);
        end
    end

`ifdef ALU_RS_AGE_ORDER_EN
    logic [IW-1:0] best_age;
    // Strictly-greater comparison keeps the lowest index on equal ages.
    always_comb begin
        sel_found = 1'b0;
        sel_ix    = '0;
        best_age  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cand[i] && (!sel_found || (age_reg[i] > best_age))) begin
                sel_found = 1'b1;
                sel_ix    = IW'(i);
                best_age  = age_reg[i];
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_ix    = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_ix    = IW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_reg     <= '0;
            alu_valid_reg <= 1'b0;
            alu_rval1_reg <= '0;
            alu_rval2_reg <= '0;
            alu_func_reg  <= '0;
            alu_rob_reg   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                busy_reg[i] <= 1'b0;
                func_reg[i] <= '0;
                rob_reg[i]  <= '0;
                v1_reg[i]   <= '0;
                v2_reg[i]   <= '0;
                rdy1_reg[i] <= 1'b0;
                rdy2_reg[i] <= 1'b0;
                q1_reg[i]   <= '0;
                q2_reg[i]   <= '0;
`ifdef ALU_RS_AGE_ORDER_EN
                age_reg[i]  <= '0;
`endif
            end
        end else if (flush_in) begin
            count_reg     <= '0;
            alu_valid_reg <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                busy_reg[i] <= 1'b0;
            end
        end else begin
            alu_valid_reg <= dispatch;
            if (dispatch) begin
                alu_rval1_reg <= v1_reg[sel_ix];
                alu_rval2_reg <= v2_reg[sel_ix];
                alu_func_reg  <= func_reg[sel_ix];
                alu_rob_reg   <= rob_reg[sel_ix];
            end
            count_reg <= count_reg + CW'(issue_fire) - CW'(dispatch);
            // free_ix is never the dispatching slot: a selected entry is busy.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (issue_fire && (free_ix == IW'(i))) begin
                    busy_reg[i] <= 1'b1;
                    func_reg[i] <= issue_aluFunc_in;
                    rob_reg[i]  <= issue_rob_ix_in;
                    v1_reg[i]   <= new_v1;
                    v2_reg[i]   <= new_v2;
                    rdy1_reg[i] <= new_rdy1;
                    rdy2_reg[i] <= new_rdy2;
                    q1_reg[i]   <= issue_q1_in;
                    q2_reg[i]   <= issue_q2_in;
                end else begin
                    if (dispatch && (sel_ix == IW'(i))) busy_reg[i] <= 1'b0;
                    if (hit1[i]) begin
                        v1_reg[i]   <= cdb_data_in;
                        rdy1_reg[i] <= 1'b1;
                    end
                    if (hit2[i]) begin
                        v2_reg[i]   <= cdb_data_in;
                        rdy2_reg[i] <= 1'b1;
                    end
                end
`ifdef ALU_RS_AGE_ORDER_EN
                if (issue_fire) begin
                    if (free_ix == IW'(i)) begin
                        age_reg[i] <= '0;
                    end else if (busy_reg[i] && (age_reg[i] != '1)) begin
                        age_reg[i] <= age_reg[i] + 1'b1;
                    end
                end
`endif
            end
        end
    end

    assign alu_valid_out   = alu_valid_reg;
    assign alu_rval1_out   = alu_rval1_reg;
    assign alu_rval2_out   = alu_rval2_reg;
    assign alu_aluFunc_out = alu_func_reg;
    assign alu_rob_ix_out  = alu_rob_reg;
    assign count_out       = count_reg;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed issue/CDB stimulus pushes expected dispatches; a negedge monitor pops and compares.
module tb_alu_rs;
    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        issue_valid_in = 1'b0;
    logic        issue_ready_out;
    logic [3:0]  issue_aluFunc_in = '0;
    logic [2:0]  issue_rob_ix_in = '0;
    logic [31:0] issue_v1_in = '0;
    logic [31:0] issue_v2_in = '0;
    logic        issue_rdy1_in = 1'b0;
    logic        issue_rdy2_in = 1'b0;
    logic [2:0]  issue_q1_in = '0;
    logic [2:0]  issue_q2_in = '0;
    logic        cdb_valid_in = 1'b0;
    logic [2:0]  cdb_rob_ix_in = '0;
    logic [31:0] cdb_data_in = '0;
    logic        alu_ready_in = 1'b1;
    logic        alu_valid_out;
    logic [31:0] alu_rval1_out;
    logic [31:0] alu_rval2_out;
    logic [3:0]  alu_aluFunc_out;
    logic [2:0]  alu_rob_ix_out;
    logic [2:0]  count_out;

    typedef struct packed {
        logic [3:0]  func;
        logic [2:0]  rob;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    alu_rs #(.ROB_IX(2), .NUM_ENTRIES(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
        .issue_aluFunc_in(issue_aluFunc_in), .issue_rob_ix_in(issue_rob_ix_in),
        .issue_v1_in(issue_v1_in), .issue_v2_in(issue_v2_in),
        .issue_rdy1_in(issue_rdy1_in), .issue_rdy2_in(issue_rdy2_in),
        .issue_q1_in(issue_q1_in), .issue_q2_in(issue_q2_in),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_ix_in(cdb_rob_ix_in), .cdb_data_in(cdb_data_in),
        .alu_ready_in(alu_ready_in), .alu_valid_out(alu_valid_out),
        .alu_rval1_out(alu_rval1_out), .alu_rval2_out(alu_rval2_out),
        .alu_aluFunc_out(alu_aluFunc_out), .alu_rob_ix_out(alu_rob_ix_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: every dispatch pulse must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (rst_in && alu_valid_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dispatch unexpected: func=%0h rob=%0h v1=%0h v2=%0h required=none",
                         alu_aluFunc_out, alu_rob_ix_out, alu_rval1_out, alu_rval2_out);
            end else begin
                exp_t e;
                exp_t a;
                e = exp_q.pop_front();
                a = '{func: alu_aluFunc_out, rob: alu_rob_ix_out, v1: alu_rval1_out, v2: alu_rval2_out};
                if (a !== e) begin
                    bad++;
                    $display("FAIL dispatch: actual func=%0h rob=%0h v1=%0h v2=%0h required func=%0h rob=%0h v1=%0h v2=%0h",
                             a.func, a.rob, a.v1, a.v2, e.func, e.rob, e.v1, e.v2);
                end else begin
                    $display("ok   dispatch func=%0h rob=%0h v1=%0h v2=%0h", a.func, a.rob, a.v1, a.v2);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_issue(input logic [3:0] f, input logic [2:0] rob,
                            input logic [31:0] v1, input logic r1, input logic [2:0] q1,
                            input logic [31:0] v2, input logic r2, input logic [2:0] q2);
        issue_aluFunc_in = f;
        issue_rob_ix_in  = rob;
        issue_v1_in      = v1;
        issue_rdy1_in    = r1;
        issue_q1_in      = q1;
        issue_v2_in      = v2;
        issue_rdy2_in    = r2;
        issue_q2_in      = q2;
        issue_valid_in   = 1'b1;
        cycle();
        issue_valid_in   = 1'b0;
    endtask

    task automatic push(input logic [3:0] f, input logic [2:0] rob, input logic [31:0] v1, input logic [31:0] v2);
        exp_q.push_back('{func: f, rob: rob, v1: v1, v2: v2});
    endtask

    initial begin
        // Reset state
        #12;
        check("reset count", 32'(count_out), 0);
        check("reset valid", 32'(alu_valid_out), 0);
        check("reset rval1", alu_rval1_out, 0);
        #11 rst_in = 1'b1;
        #1;
        check("ready after reset", 32'(issue_ready_out), 1);
        cycle();

        // Single op: dispatch one cycle after issue
        push(ADD, 3'd3, 32'd5, 32'd7);
        do_issue(ADD, 3'd3, 32'd5, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0);
        check("single valid E", 32'(alu_valid_out), 0);
        check("single count E", 32'(count_out), 1);
        cycle();
        check("single valid E+1", 32'(alu_valid_out), 1);
        check("single count E+1", 32'(count_out), 0);
        cycle();
        check("single pulse ends", 32'(alu_valid_out), 0);

        // Wakeup through CDB
        push(SUB, 3'd5, 32'd10, 32'd1);
        do_issue(SUB, 3'd5, 32'd0, 1'b0, 3'd2, 32'd1, 1'b1, 3'd0);
        check("wake wait E", 32'(alu_valid_out), 0);
        cycle();
        check("wake wait E+1", 32'(alu_valid_out), 0);
        cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd2; cdb_data_in = 32'd10;
        cycle();
        cdb_valid_in = 1'b0;
        check("wake cycle no dispatch", 32'(alu_valid_out), 0);
        cycle();
        check("wake dispatch", 32'(alu_valid_out), 1);
        cycle();

        // Same-cycle capture at issue
        push(AND, 3'd6, 32'd3, 32'hFFFF_FFFF);
        cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd4; cdb_data_in = 32'hFFFF_FFFF;
        do_issue(AND, 3'd6, 32'd3, 1'b1, 3'd0, 32'd0, 1'b0, 3'd4);
        cdb_valid_in = 1'b0;
        cycle();
        check("capture dispatch", 32'(alu_valid_out), 1);
        cycle();

        // Full station under backpressure
        alu_ready_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(4'(k + 4), 3'(k), 32'(k * 16 + 1), 32'(k * 16 + 2));
            do_issue(4'(k + 4), 3'(k), 32'(k * 16 + 1), 1'b1, 3'd0, 32'(k * 16 + 2), 1'b1, 3'd0);
        end
        check("full count", 32'(count_out), 4);
        check("full ready", 32'(issue_ready_out), 0);
        do_issue(4'd9, 3'd7, 32'hDEAD, 1'b1, 3'd0, 32'hBEEF, 1'b1, 3'd0);
        check("fifth ignored count", 32'(count_out), 4);
        check("backpressure no dispatch", 32'(alu_valid_out), 0);
        alu_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("drain pulse", 32'(alu_valid_out), 1);
            if (k == 0) check("ready after first drain", 32'(issue_ready_out), 1);
        end
        check("drained count", 32'(count_out), 0);
        cycle();
        check("drain done", 32'(alu_valid_out), 0);

        // Flush beats a pending dispatch
        alu_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_issue(ADD, 3'(k), 32'(k), 1'b1, 3'd0, 32'(k), 1'b1, 3'd0);
        end
        check("pre-flush count", 32'(count_out), 3);
        flush_in = 1'b1;
        alu_ready_in = 1'b1;
        cycle();
        flush_in = 1'b0;
        check("flush count", 32'(count_out), 0);
        check("flush valid", 32'(alu_valid_out), 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("post-flush quiet", 32'(alu_valid_out), 0);
        end

        // Asynchronous reset mid-operation
        push(ADD, 3'd2, 32'h1234, 32'h5678);
        do_issue(ADD, 3'd2, 32'h1234, 1'b1, 3'd0, 32'h5678, 1'b1, 3'd0);
        do_issue(SUB, 3'd3, 32'd0, 1'b0, 3'd5, 32'd9, 1'b1, 3'd0);
        check("pre-reset valid", 32'(alu_valid_out), 1);
        check("pre-reset count", 32'(count_out), 1);
        #6 rst_in = 1'b0;
        #1;
        check("async reset count", 32'(count_out), 0);
        check("async reset valid", 32'(alu_valid_out), 0);
        check("async reset rval1", alu_rval1_out, 0);
        check("async reset rval2", alu_rval2_out, 0);
        cycle();
        rst_in = 1'b1;
        check("ready after mid reset", 32'(issue_ready_out), 1);
        cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd5; cdb_data_in = 32'd1;
        cycle();
        cdb_valid_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("discarded entry quiet", 32'(alu_valid_out), 0);
        end

        // Selection order when two entries wake together
        alu_ready_in = 1'b0;
        do_issue(ADD, 3'd1, 32'd100, 1'b1, 3'd0, 32'd0, 1'b1, 3'd0);
        do_issue(SUB, 3'd2, 32'd0, 1'b0, 3'd7, 32'd2, 1'b1, 3'd0);
        check("order count two", 32'(count_out), 2);
        push(ADD, 3'd1, 32'd100, 32'd0);
        alu_ready_in = 1'b1;
        cycle();
        check("order first free", 32'(alu_valid_out), 1);
        alu_ready_in = 1'b0;
        do_issue(OR, 3'd4, 32'd0, 1'b0, 3'd7, 32'd4, 1'b1, 3'd0);
        check("order count refill", 32'(count_out), 2);
`ifdef ALU_RS_AGE_ORDER_EN
        push(SUB, 3'd2, 32'h77, 32'd2);
        push(OR,  3'd4, 32'h77, 32'd4);
`else
        push(OR,  3'd4, 32'h77, 32'd4);
        push(SUB, 3'd2, 32'h77, 32'd2);
`endif
        alu_ready_in = 1'b1;
        cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd7; cdb_data_in = 32'h77;
        cycle();
        cdb_valid_in = 1'b0;
        check("order wake cycle", 32'(alu_valid_out), 0);
        cycle();
        check("order dispatch 1", 32'(alu_valid_out), 1);
        cycle();
        check("order dispatch 2", 32'(alu_valid_out), 1);
        cycle();
        check("order done", 32'(alu_valid_out), 0);
        check("order count", 32'(count_out), 0);

        cycle();
        cycle();
        check("scoreboard empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
